pll_lock_supervisor: RTL and testbench



---
 rtl/pll_lock_supervisor_pkg.sv | 27 ++
 rtl/pll_lock_supervisor_if.sv | 45 ++++
 rtl/pll_lock_supervisor_sync_2ff.sv | 26 ++
 rtl/pll_lock_supervisor.sv | 140 ++++++++++++++
 tb/tb_pll_lock_supervisor.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pll_lock_supervisor_pkg.sv
// Shared state encodings and default timing constants for the rPLL lock supervisor.
package pll_sup_pkg;

  localparam int unsigned RST_CYCLES_DEF    = 16;
  localparam int unsigned LOCK_TIMEOUT_DEF  = 27000;
  localparam int unsigned STABLE_CYCLES_DEF = 2700;
  localparam int unsigned MAX_RETRY_DEF     = 3;
  localparam int unsigned STATE_W           = 3;
  localparam int unsigned STATS_W           = 8;

  typedef enum logic [STATE_W-1:0] {
    ST_RESET_PLL = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABILIZE = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } pll_state_e;

  // Largest of the three phase lengths; sizes the shared cycle counter.
  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pll_lock_supervisor_if.sv
// Supervisor <-> PLL / reset-tree signal bundle. lock_loss_cnt exists only with PLL_SUP_STATS_EN.
interface pll_lock_supervisor_if;
  import pll_sup_pkg::*;

  logic               pll_lock;
  logic               retry_req;
  logic               pll_reset;
  logic               sys_rst_n;
  logic               locked;
  logic               fault;
  logic               lost_lock;
  logic [STATE_W-1:0] state;
`ifdef PLL_SUP_STATS_EN
  logic [STATS_W-1:0] lock_loss_cnt;
`endif

  modport master (
    input  pll_lock,
    input  retry_req,
    output pll_reset,
    output sys_rst_n,
    output locked,
    output fault,
    output lost_lock,
    output state
`ifdef PLL_SUP_STATS_EN
    , output lock_loss_cnt
`endif
  );

  modport slave (
    output pll_lock,
    output retry_req,
    input  pll_reset,
    input  sys_rst_n,
    input  locked,
    input  fault,
    input  lost_lock,
    input  state
`ifdef PLL_SUP_STATS_EN
    , input lock_loss_cnt
`endif
  );

endinterface

// File: rtl/pll_lock_supervisor_sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs; resets to 0.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/pll_lock_supervisor.sv
// rPLL start-up sequencer and lock supervisor in the crystal clock domain.
// Optional lock-loss statistics counter enabled by defining PLL_SUP_STATS_EN.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int unsigned RST_CYCLES    = RST_CYCLES_DEF,
  parameter int unsigned LOCK_TIMEOUT  = LOCK_TIMEOUT_DEF,
  parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEF,
  parameter int unsigned MAX_RETRY     = MAX_RETRY_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pll_lock_supervisor_if.master sup
);

  localparam int unsigned CNT_MAX = max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned RETRY_W = $clog2(MAX_RETRY + 1);

  localparam logic [CNT_W-1:0]   RST_TERM = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TO_TERM  = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   STB_TERM = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CNT_SAT  = {CNT_W{1'b1}};
  localparam logic [RETRY_W-1:0] RETRY_LIM = RETRY_W'(MAX_RETRY);

  logic               w_lock_s;
  pll_state_e         r_state;
  pll_state_e         w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [RETRY_W-1:0] r_retry;
  logic [RETRY_W-1:0] w_retry_nxt;
  logic               w_lost_lock;
  logic               r_pll_reset;
  logic               r_sys_rst_n;
  logic               r_locked;
  logic               r_fault;
  logic               r_lost_lock;

  sync_2ff #(.WIDTH(1)) u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (sup.pll_lock),
    .o_q   (w_lock_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_RESET_PLL;
    else        r_state <= w_state_nxt;
  end

  // Next state and retry bookkeeping; lock takes priority over timeout in WAIT_LOCK.
  always_comb begin
    w_state_nxt = r_state;
    w_retry_nxt = r_retry;
    unique case (r_state)
      ST_RESET_PLL: begin
        if (r_cnt == RST_TERM) w_state_nxt = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (w_lock_s) begin
          w_state_nxt = ST_STABILIZE;
        end else if (r_cnt == TO_TERM) begin
          w_retry_nxt = r_retry + RETRY_W'(1);
          w_state_nxt = (w_retry_nxt == RETRY_LIM) ? ST_FAULT : ST_RESET_PLL;
        end
      end
      ST_STABILIZE: begin
        if (!w_lock_s) begin
          w_state_nxt = ST_WAIT_LOCK;
        end else if (r_cnt == STB_TERM) begin
          w_state_nxt = ST_RUN;
          w_retry_nxt = '0;
        end
      end
      ST_RUN: begin
        if (!w_lock_s) w_state_nxt = ST_RESET_PLL;
      end
      ST_FAULT: begin
        if (sup.retry_req) begin
          w_state_nxt = ST_RESET_PLL;
          w_retry_nxt = '0;
        end
      end
      default: begin
        w_state_nxt = ST_RESET_PLL;
        w_retry_nxt = '0;
      end
    endcase
  end

  assign w_lost_lock = (r_state == ST_RUN) && (w_state_nxt == ST_RESET_PLL);

  // Shared phase counter: cleared on any state change, saturates otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_retry <= '0;
    end else begin
      r_retry <= w_retry_nxt;
      if (w_state_nxt != r_state) r_cnt <= '0;
      else if (r_cnt != CNT_SAT)  r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Moore outputs decoded from the next state so they move with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pll_reset <= 1'b1;
      r_sys_rst_n <= 1'b0;
      r_locked    <= 1'b0;
      r_fault     <= 1'b0;
      r_lost_lock <= 1'b0;
    end else begin
      r_pll_reset <= (w_state_nxt == ST_RESET_PLL) || (w_state_nxt == ST_FAULT);
      r_sys_rst_n <= (w_state_nxt == ST_RUN);
      r_locked    <= (w_state_nxt == ST_RUN);
      r_fault     <= (w_state_nxt == ST_FAULT);
      r_lost_lock <= w_lost_lock;
    end
  end

`ifdef PLL_SUP_STATS_EN
  logic [STATS_W-1:0] r_lock_loss_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                              r_lock_loss_cnt <= '0;
    else if (w_lost_lock && (r_lock_loss_cnt != {STATS_W{1'b1}})) r_lock_loss_cnt <= r_lock_loss_cnt + STATS_W'(1);
  end

  assign sup.lock_loss_cnt = r_lock_loss_cnt;
`endif

  assign sup.pll_reset = r_pll_reset;
  assign sup.sys_rst_n = r_sys_rst_n;
  assign sup.locked    = r_locked;
  assign sup.fault     = r_fault;
  assign sup.lost_lock = r_lost_lock;
  assign sup.state     = r_state;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Scoreboard bench for pll_lock_supervisor: expected output-vector changes are queued
// with their clock-edge index and checked by an independent monitor.
module tb_pll_lock_supervisor;

  // Observed vector: {state[2:0], pll_reset, sys_rst_n, locked, fault, lost_lock}
  localparam logic [7:0] V_RESET = 8'b000_10000;
  localparam logic [7:0] V_WAIT  = 8'b001_00000;
  localparam logic [7:0] V_STAB  = 8'b010_00000;
  localparam logic [7:0] V_RUN   = 8'b011_01100;
  localparam logic [7:0] V_FAULT = 8'b100_10010;
  localparam logic [7:0] V_LOST  = 8'b000_10001;

  typedef struct {
    int         cyc;
    logic [7:0] v;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_cmp;
  int   n_err;
  exp_t q[$];

  pll_lock_supervisor_if sup ();

  pll_lock_supervisor #(
    .RST_CYCLES    (4),
    .LOCK_TIMEOUT  (32),
    .STABLE_CYCLES (8),
    .MAX_RETRY     (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sup   (sup)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] obs();
    return {sup.state, sup.pll_reset, sup.sys_rst_n, sup.locked, sup.fault, sup.lost_lock};
  endfunction

  function automatic void push(input int c, input logic [7:0] v);
    exp_t e;
    e.cyc = c;
    e.v   = v;
    q.push_back(e);
  endfunction

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%b expected=%b", name, cyc, got, exp);
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // One-cycle lock drop from RUN and full recovery back to RUN.
  task automatic lose_and_recover();
    int t;
    t = cyc;
    push(t + 3, V_LOST);
    push(t + 4, V_RESET);
    push(t + 7, V_WAIT);
    push(t + 8, V_STAB);
    push(t + 16, V_RUN);
    sup.pll_lock = 1'b0;
    @(negedge clk);
    sup.pll_lock = 1'b1;
    wait_until(t + 18);
    check("recover_run", obs(), V_RUN);
  endtask

  // Monitor: every change of the observed vector must match the next queued expectation.
  initial begin
    logic [7:0] prev;
    logic [7:0] cur;
    exp_t       e;
    n_cmp = 0;
    n_err = 0;
    prev  = V_RESET;
    forever begin
      @(negedge clk);
      cur = obs();
      if (cur !== prev) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_change cyc=%0d got=%b", cyc, cur);
        end else begin
          e = q.pop_front();
          if ((cur !== e.v) || (cyc != e.cyc)) begin
            n_err++;
            $display("FAIL transition got=%b@%0d expected=%b@%0d", cur, cyc, e.v, e.cyc);
          end
        end
        prev = cur;
      end
    end
  end

  initial begin
    int t;
    rst_n         = 1'b0;
    sup.pll_lock  = 1'b1;
    sup.retry_req = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_state", obs(), V_RESET);
`ifdef PLL_SUP_STATS_EN
    check("stats_reset", sup.lock_loss_cnt, 8'd0);
`endif

    // Start-up with lock already present
    rst_n = 1'b1;
    t = cyc;
    push(t + 4, V_WAIT);
    push(t + 5, V_STAB);
    push(t + 13, V_RUN);
    wait_until(t + 16);
    check("startup_run", obs(), V_RUN);

    // Lock loss in RUN
    lose_and_recover();
`ifdef PLL_SUP_STATS_EN
    check("stats_one", sup.lock_loss_cnt, 8'd1);
`endif

    // Lock drops for 3 cycles while STABILIZE count is 5
    t = cyc;
    push(t + 3, V_LOST);
    push(t + 4, V_RESET);
    push(t + 7, V_WAIT);
    push(t + 8, V_STAB);
    push(t + 16, V_WAIT);
    push(t + 19, V_STAB);
    push(t + 27, V_RUN);
    sup.pll_lock = 1'b0;
    @(negedge clk);
    sup.pll_lock = 1'b1;
    wait_until(t + 13);
    sup.pll_lock = 1'b0;
    wait_until(t + 16);
    sup.pll_lock = 1'b1;
    wait_until(t + 29);
    check("stab_glitch_run", obs(), V_RUN);

    // Permanent lock loss: three timeouts, then FAULT; retry_req ignored in WAIT_LOCK
    t = cyc;
    push(t + 3, V_LOST);
    push(t + 4, V_RESET);
    push(t + 7, V_WAIT);
    push(t + 39, V_RESET);
    push(t + 43, V_WAIT);
    push(t + 75, V_RESET);
    push(t + 79, V_WAIT);
    push(t + 111, V_FAULT);
    sup.pll_lock = 1'b0;
    wait_until(t + 20);
    sup.retry_req = 1'b1;
    @(negedge clk);
    sup.retry_req = 1'b0;
    wait_until(t + 115);
    check("fault_entry", obs(), V_FAULT);

    // FAULT is sticky with lock back; retry_req restarts
    sup.pll_lock = 1'b1;
    repeat (5) @(negedge clk);
    check("fault_sticky", obs(), V_FAULT);
    t = cyc;
    push(t + 1, V_RESET);
    push(t + 5, V_WAIT);
    push(t + 6, V_STAB);
    push(t + 14, V_RUN);
    sup.retry_req = 1'b1;
    @(negedge clk);
    sup.retry_req = 1'b0;
    wait_until(t + 16);
    check("retry_run", obs(), V_RUN);

    // Asynchronous reset from RUN
    @(posedge clk);
    #2;
    push(cyc, V_RESET);
    rst_n = 1'b0;
    #1;
    check("async_rst_run", obs(), V_RESET);
`ifdef PLL_SUP_STATS_EN
    check("stats_cleared", sup.lock_loss_cnt, 8'd0);
`endif
    @(negedge clk);
    sup.pll_lock = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    t = cyc;
    push(t + 4, V_WAIT);
    push(t + 36, V_RESET);
    push(t + 40, V_WAIT);
    push(t + 72, V_RESET);
    push(t + 76, V_WAIT);
    push(t + 108, V_FAULT);
    wait_until(t + 110);
    check("fault_from_reset", obs(), V_FAULT);

    // Asynchronous reset from FAULT
    @(posedge clk);
    #2;
    push(cyc, V_RESET);
    rst_n = 1'b0;
    #1;
    check("async_rst_fault", obs(), V_RESET);
    sup.pll_lock = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    t = cyc;
    push(t + 4, V_WAIT);
    push(t + 5, V_STAB);
    push(t + 13, V_RUN);
    wait_until(t + 16);
    check("restart_run", obs(), V_RUN);

    // 300 lock-loss events
    repeat (300) lose_and_recover();
`ifdef PLL_SUP_STATS_EN
    check("stats_saturate", sup.lock_loss_cnt, 8'd255);
`endif

    repeat (5) @(negedge clk);
    n_cmp++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL pending_expectations remaining=%0d required=0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
